// File: rtl/spring_controller_pkg.sv
// Shared definitions for the plunger/spring stage.
// Holds the spring state type, the geometry and gain constants used both as
// RTL parameter defaults and by the spring drawing object, and the helper
// that converts compression to the spring top pixel row.
package spring_controller_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHARGING  = 2'd1,
    RELEASING = 2'd2
  } spring_state_t;

  localparam int SPRING_REST_TOP_Y      = 400;
  localparam int SPRING_MAX_COMPRESSION = 32;
  localparam int SPRING_CHARGE_STEP     = 1;
  localparam int SPRING_RELEASE_STEP    = 8;
  localparam int SPRING_LAUNCH_GAIN     = 10;

  // Spring top row: rest position pushed down by the compression.
  function automatic logic signed [10:0] spring_top_y(input int rest, input logic [5:0] comp);
    return 11'(rest) + $signed({5'd0, comp});
  endfunction

endpackage

// File: rtl/spring_controller_if.sv
// Signal bundle between the game control logic and the spring stage.
//   startOfFrame               one-clock frame tick
//   keyIsPressed               launch key level
//   pause                      freeze game
//   reset_level                synchronous level restart
//   collisionSmileySpring      raw ball/spring overlap level
//   springSpeedY               spring speed to ball (negative = upward launch)
//   collisionSmileySpringPulse one-clock collision pulse to ball controller
//   springTopY                 spring top pixel row
//   compression                current compression in pixels
// The slave modport is the spring stage; master is the side that drives it.
interface spring_controller_if;
  logic               startOfFrame;
  logic               keyIsPressed;
  logic               pause;
  logic               reset_level;
  logic               collisionSmileySpring;
  logic signed [31:0] springSpeedY;
  logic               collisionSmileySpringPulse;
  logic signed [10:0] springTopY;
  logic [5:0]         compression;

  modport slave (
    input  startOfFrame, keyIsPressed, pause, reset_level, collisionSmileySpring,
    output springSpeedY, collisionSmileySpringPulse, springTopY, compression
  );

  modport master (
    output startOfFrame, keyIsPressed, pause, reset_level, collisionSmileySpring,
    input  springSpeedY, collisionSmileySpringPulse, springTopY, compression
  );
endinterface

// File: rtl/spring_controller_edge_pulse.sv
// Registered rising-edge detector, reusable for bumper collision pulses.
//   clk, resetN  clock and asynchronous active-low reset
//   din          level input
//   clr          synchronous clear: no pulse, history reloads din
//   gate         when low the pulse is suppressed but history keeps tracking
//   force_i      requests a pulse independent of an edge (merged with an edge)
//   pulse        registered one-clock pulse
module edge_pulse (
  input  logic clk,
  input  logic resetN,
  input  logic din,
  input  logic clr,
  input  logic gate,
  input  logic force_i,
  output logic pulse
);

  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    // History always follows the input so a resume or a clear never sees
    // a stale low and fires a spurious edge.
    prev_d  = din;
    pulse_d = 1'b0;
    if (!clr && gate) begin
      pulse_d = (din && !prev_q) || force_i;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/spring_controller.sv
// Plunger/spring stage feeding the ball controller.
// Charges compression per frame while the launch key is held, releases it
// when the key is let go, and reports the launch speed, a one-clock
// collision pulse and the spring top row.
//   clk      system clock
//   resetN   asynchronous active-low reset
//   bus      spring_controller_if.slave: frame tick, key, pause, level
//            restart and collision level in; speed, pulse, top row and
//            compression out (all registered)
module spring_controller
  import spring_controller_pkg::*;
#(
  parameter int REST_TOP_Y      = SPRING_REST_TOP_Y,
  parameter int MAX_COMPRESSION = SPRING_MAX_COMPRESSION,
  parameter int CHARGE_STEP     = SPRING_CHARGE_STEP,
  parameter int RELEASE_STEP    = SPRING_RELEASE_STEP,
  parameter int LAUNCH_GAIN     = SPRING_LAUNCH_GAIN
) (
  input  logic              clk,
  input  logic              resetN,
  spring_controller_if.slave bus
);

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_CHARGING  = CHARGING;
  localparam logic [1:0] ST_RELEASING = RELEASING;

  localparam logic [6:0]         MAX_C  = 7'(MAX_COMPRESSION);
  localparam logic [6:0]         CHG    = 7'(CHARGE_STEP);
  localparam logic [6:0]         REL    = 7'(RELEASE_STEP);
  localparam logic signed [31:0] GAIN   = 32'(LAUNCH_GAIN);
  localparam logic signed [10:0] REST_Y = 11'(REST_TOP_Y);

  // Add one charge step, clamped at full compression (never wraps).
  function automatic logic [5:0] sat_charge(input logic [5:0] c);
    logic [6:0] s;
    s = {1'b0, c} + CHG;
    if (s > MAX_C) s = MAX_C;
    return s[5:0];
  endfunction

  // Remove one release step, clamped at zero.
  function automatic logic [5:0] sat_release(input logic [5:0] c);
    if ({1'b0, c} > REL) return 6'({1'b0, c} - REL);
    return 6'd0;
  endfunction

  function automatic logic signed [31:0] launch_speed(input logic [5:0] c);
    logic signed [31:0] cs;
    cs = $signed({26'd0, c});
    return -(cs * GAIN);
  endfunction

  logic [1:0]         state_q, state_d;
  logic [5:0]         comp_q, comp_d;
  logic signed [31:0] launch_q, launch_d;
  logic signed [31:0] speed_q, speed_d;
  logic signed [10:0] topy_q, topy_d;
  logic               enter_rel;
  logic               pulse;

  always_comb begin
    state_d   = state_q;
    comp_d    = comp_q;
    launch_d  = launch_q;
    speed_d   = speed_q;
    enter_rel = 1'b0;
    if (bus.reset_level) begin
      state_d  = ST_IDLE;
      comp_d   = 6'd0;
      launch_d = '0;
      speed_d  = '0;
    end else if (bus.startOfFrame && !bus.pause) begin
      case (state_q)
        ST_IDLE: begin
          speed_d = '0;
          if (bus.keyIsPressed) state_d = ST_CHARGING;
        end
        ST_CHARGING: begin
          speed_d = '0;
          if (bus.keyIsPressed) begin
            comp_d = sat_charge(comp_q);
          end else if (comp_q == 6'd0) begin
            state_d = ST_IDLE;
          end else begin
            // Speed is driven on the entry edge so it lines up with the
            // launch pulse for a ball already resting on the spring.
            launch_d  = launch_speed(comp_q);
            speed_d   = launch_d;
            state_d   = ST_RELEASING;
            enter_rel = 1'b1;
          end
        end
        ST_RELEASING: begin
          comp_d  = sat_release(comp_q);
          speed_d = launch_q;
          if (comp_d == 6'd0) begin
            state_d = ST_IDLE;
            speed_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          speed_d = '0;
        end
      endcase
    end
    topy_d = spring_top_y(REST_TOP_Y, comp_d);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      comp_q   <= 6'd0;
      launch_q <= '0;
      speed_q  <= '0;
      topy_q   <= REST_Y;
    end else begin
      state_q  <= state_d;
      comp_q   <= comp_d;
      launch_q <= launch_d;
      speed_q  <= speed_d;
      topy_q   <= topy_d;
    end
  end

  // Edge pulses plus a forced pulse when the launch starts under the ball.
  edge_pulse u_coll_pulse (
    .clk     (clk),
    .resetN  (resetN),
    .din     (bus.collisionSmileySpring),
    .clr     (bus.reset_level),
    .gate    (!bus.pause),
    .force_i (enter_rel && bus.collisionSmileySpring),
    .pulse   (pulse)
  );

  assign bus.springSpeedY               = speed_q;
  assign bus.collisionSmileySpringPulse = pulse;
  assign bus.springTopY                 = topy_q;
  assign bus.compression                = comp_q;

endmodule
